// File: rtl/cvmcu_io_pkg.sv
// Shared definitions for the IO pad bridge: pad-config field positions,
// default sizing and the pad-config word type.
package cvmcu_io_pkg;

    // Field index of the pull-up enable inside a pad-config word
    localparam int PULLUP_BIT = 0;

    // Default sizing of the bridge
    localparam int DEF_N_IO  = 48;
    localparam int DEF_CFG_W = 6;

    // One pad-config word at the default width
    typedef logic [DEF_CFG_W-1:0] pad_cfg_t;

endpackage : cvmcu_io_pkg

// File: rtl/cvmcu_io_clk_div.sv
// Even-ratio clock divider producing a registered 50% duty-cycle output.
// The output first toggles SLOW_DIV/2 cycles after reset is released.
module cvmcu_io_clk_div
    import cvmcu_io_pkg::*;
#(
    parameter int SLOW_DIV = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic slow_clk_o
);

    localparam int HALF  = SLOW_DIV / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_slow;

    // Count half-periods and toggle the output at the end of each one
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_slow <= 1'b0;
        end else if (r_cnt == CNT_W'(HALF - 1)) begin
            r_cnt  <= '0;
            r_slow <= ~r_slow;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign slow_clk_o = r_slow;

endmodule : cvmcu_io_clk_div

// File: rtl/cvmcu_io_pad_bridge.sv
// Chip/board IO pad bridge: resolves pad values, delays them to the chip,
// latches pad configuration, tracks chip/board drive contention and
// provides a divided slow clock.
module cvmcu_io_pad_bridge
    import cvmcu_io_pkg::*;
#(
    parameter int N_IO     = DEF_N_IO,
    parameter int CFG_W    = DEF_CFG_W,
    parameter int DELAY    = 2,
    parameter int SLOW_DIV = 8,
    parameter int CNT_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_IO-1:0]       chip_out_i,
    input  logic [N_IO-1:0]       chip_oe_i,
    input  logic [N_IO*CFG_W-1:0] chip_pad_cfg_i,
    input  logic                  cfg_we_i,
    input  logic [N_IO-1:0]       board_drv_i,
    input  logic [N_IO-1:0]       board_en_i,
    input  logic                  clr_i,
    output logic [N_IO-1:0]       pad_o,
    output logic [N_IO-1:0]       io_in_o,
    output logic [N_IO*CFG_W-1:0] pad_cfg_o,
    output logic [N_IO-1:0]       contention_o,
    output logic [CNT_W-1:0]      contention_cnt_o,
    output logic                  slow_clk_o
);

    logic [N_IO*CFG_W-1:0] r_cfg;
    logic [N_IO-1:0]       r_cont;
    logic [CNT_W-1:0]      r_cnt;
    logic [N_IO-1:0]       w_pad;
    logic [N_IO-1:0]       w_cont;
    logic                  w_any_cont;

    // Per-pad resolution: chip drive beats board drive beats the pull value.
    // Contention only counts when both sides drive different values.
    genvar gi;
    generate
        for (gi = 0; gi < N_IO; gi++) begin : g_pad
            assign w_pad[gi]  = chip_oe_i[gi]  ? chip_out_i[gi]  :
                                board_en_i[gi] ? board_drv_i[gi] :
                                r_cfg[gi*CFG_W + PULLUP_BIT];
            assign w_cont[gi] = chip_oe_i[gi] & board_en_i[gi] &
                                (chip_out_i[gi] ^ board_drv_i[gi]);
        end
    endgenerate

    assign w_any_cont = |w_cont;

    // Pad-config register, loaded only on a write strobe
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cfg <= '0;
        end else if (cfg_we_i) begin
            r_cfg <= chip_pad_cfg_i;
        end
    end

    // Sticky contention flags; a clear loses against a same-cycle contention
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cont <= '0;
        end else if (clr_i) begin
            r_cont <= w_cont;
        end else begin
            r_cont <= r_cont | w_cont;
        end
    end

    // Saturating count of cycles in which at least one pad contends
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= CNT_W'(w_any_cont);
        end else if (w_any_cont && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pad-to-chip delay line of DELAY register stages
    generate
        if (DELAY == 0) begin : g_no_dly
            assign io_in_o = w_pad;
        end else begin : g_dly
            for (gi = 0; gi < DELAY; gi++) begin : g_stage
                logic [N_IO-1:0] r_stage;
                if (gi == 0) begin : g_first
                    // First stage samples the resolved pad values
                    always_ff @(posedge clk_i) begin
                        if (rst_i) r_stage <= '0;
                        else       r_stage <= w_pad;
                    end
                end else begin : g_rest
                    // Later stages shift the previous stage along
                    always_ff @(posedge clk_i) begin
                        if (rst_i) r_stage <= '0;
                        else       r_stage <= g_stage[gi-1].r_stage;
                    end
                end
            end
            assign io_in_o = g_stage[DELAY-1].r_stage;
        end
    endgenerate

    cvmcu_io_clk_div #(
        .SLOW_DIV (SLOW_DIV)
    ) u_clk_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .slow_clk_o (slow_clk_o)
    );

    assign pad_o            = w_pad;
    assign pad_cfg_o        = r_cfg;
    assign contention_o     = r_cont;
    assign contention_cnt_o = r_cnt;

endmodule : cvmcu_io_pad_bridge

// File: tb/tb_cvmcu_io_pad_bridge.sv
// Directed self-checking bench for the IO pad bridge.
module tb_cvmcu_io_pad_bridge;

    localparam int N_IO     = 8;
    localparam int CFG_W    = 6;
    localparam int DELAY    = 2;
    localparam int SLOW_DIV = 8;
    localparam int CNT_W    = 4;

    logic                  clk;
    logic                  rst;
    logic [N_IO-1:0]       chip_out;
    logic [N_IO-1:0]       chip_oe;
    logic [N_IO*CFG_W-1:0] chip_pad_cfg;
    logic                  cfg_we;
    logic [N_IO-1:0]       board_drv;
    logic [N_IO-1:0]       board_en;
    logic                  clr;
    logic [N_IO-1:0]       pad;
    logic [N_IO-1:0]       io_in;
    logic [N_IO*CFG_W-1:0] pad_cfg;
    logic [N_IO-1:0]       cont;
    logic [CNT_W-1:0]      cnt;
    logic                  slow;

    int n_tests = 0;
    int n_fail  = 0;

    cvmcu_io_pad_bridge #(
        .N_IO     (N_IO),
        .CFG_W    (CFG_W),
        .DELAY    (DELAY),
        .SLOW_DIV (SLOW_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .chip_out_i       (chip_out),
        .chip_oe_i        (chip_oe),
        .chip_pad_cfg_i   (chip_pad_cfg),
        .cfg_we_i         (cfg_we),
        .board_drv_i      (board_drv),
        .board_en_i       (board_en),
        .clr_i            (clr),
        .pad_o            (pad),
        .io_in_o          (io_in),
        .pad_cfg_o        (pad_cfg),
        .contention_o     (cont),
        .contention_cnt_o (cnt),
        .slow_clk_o       (slow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        chip_out  = '0;
        chip_oe   = '0;
        board_drv = '0;
        board_en  = '0;
        cfg_we    = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        chip_pad_cfg = '0;
        idle_inputs();
        do_reset();

        // Reset state
        check_eq("rst_pad",    64'(pad),     64'h0);
        check_eq("rst_io_in",  64'(io_in),   64'h0);
        check_eq("rst_cfg",    64'(pad_cfg), 64'h0);
        check_eq("rst_cont",   64'(cont),    64'h0);
        check_eq("rst_cnt",    64'(cnt),     64'h0);
        check_eq("rst_slow",   64'(slow),    64'h0);

        // Pull-up on pad 3 reaches the pad at once and the chip two cycles later
        chip_pad_cfg = '0;
        chip_pad_cfg[3*CFG_W] = 1'b1;
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        chip_pad_cfg = '0;
        check_eq("cfg_latched", 64'(pad_cfg), 64'h1 << (3*CFG_W));
        check_eq("pull_pad3",   64'(pad),     64'h08);
        step();
        check_eq("io_in_d1",    64'(io_in),   64'h00);
        step();
        check_eq("io_in_d2",    64'(io_in),   64'h08);
        check_eq("cfg_hold",    64'(pad_cfg), 64'h1 << (3*CFG_W));

        // Board drive used when chip is not driving
        board_en = 8'h40; board_drv = 8'h40;
        #1;
        check_eq("board_pad6", 64'(pad), 64'h48);
        idle_inputs();

        // Chip 0 vs board 1 on pad 5 for three cycles
        chip_oe = 8'h20; chip_out = 8'h00;
        board_en = 8'h20; board_drv = 8'h20;
        #1;
        check_eq("cont5_pad",   64'(pad),  64'h08);
        check_eq("cont5_pre",   64'(cont), 64'h00);
        step();
        check_eq("cont5_flag1", 64'(cont), 64'h20);
        check_eq("cont5_cnt1",  64'(cnt),  64'h1);
        step();
        step();
        check_eq("cont5_cnt3",  64'(cnt),  64'h3);
        idle_inputs();
        step();
        check_eq("cont5_sticky", 64'(cont), 64'h20);
        check_eq("cont5_cnthold", 64'(cnt), 64'h3);

        // Two pads contending in one cycle count once
        chip_oe = 8'h06; chip_out = 8'h02;
        board_en = 8'h06; board_drv = 8'h04;
        #1;
        check_eq("cont12_pad", 64'(pad), 64'h0A);
        step();
        check_eq("cont12_cnt",  64'(cnt),  64'h4);
        check_eq("cont12_flag", 64'(cont), 64'h26);
        idle_inputs();

        // Equal values from both sides are not contention
        chip_oe = 8'h10; chip_out = 8'h10;
        board_en = 8'h10; board_drv = 8'h10;
        step();
        check_eq("eq_pad",  64'(pad),  64'h18);
        check_eq("eq_cnt",  64'(cnt),  64'h4);
        check_eq("eq_flag", 64'(cont), 64'h26);
        idle_inputs();

        // Saturation: 20 contention cycles on pad 0
        chip_oe = 8'h01; chip_out = 8'h01; board_en = 8'h01; board_drv = 8'h00;
        for (int i = 0; i < 20; i++) step();
        check_eq("sat_cnt", 64'(cnt), 64'hF);
        step();
        check_eq("sat_hold", 64'(cnt), 64'hF);
        idle_inputs();

        // Clear without contention
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_eq("clr_cnt",  64'(cnt),  64'h0);
        check_eq("clr_flag", 64'(cont), 64'h00);

        // Clear coincident with contention on pad 0: set wins
        chip_oe = 8'h01; chip_out = 8'h00; board_en = 8'h01; board_drv = 8'h01;
        clr = 1'b1;
        step();
        idle_inputs();
        check_eq("clrset_flag", 64'(cont), 64'h01);
        check_eq("clrset_cnt",  64'(cnt),  64'h1);

        // Slow clock: rises at cycle 4, falls at cycle 8 after reset release
        do_reset();
        check_eq("rst2_cfg", 64'(pad_cfg), 64'h0);
        check_eq("rst2_pad", 64'(pad),     64'h0);
        for (int i = 0; i < 3; i++) step();
        check_eq("slow_c3", 64'(slow), 64'h0);
        step();
        check_eq("slow_c4", 64'(slow), 64'h1);
        for (int i = 0; i < 3; i++) step();
        check_eq("slow_c7", 64'(slow), 64'h1);
        step();
        check_eq("slow_c8", 64'(slow), 64'h0);

        // Reset at cycle 6 with activity, cfg write and clear pending
        rst = 1'b1;
        step();
        rst = 1'b0;
        chip_oe = 8'h01; chip_out = 8'h01; board_en = 8'h01; board_drv = 8'h00;
        for (int i = 0; i < 5; i++) step();
        check_eq("pre_rst_slow", 64'(slow), 64'h1);
        check_eq("pre_rst_cnt",  64'(cnt),  64'h5);
        chip_pad_cfg = '1;
        cfg_we = 1'b1;
        clr    = 1'b1;
        rst    = 1'b1;
        step();
        check_eq("mid_rst_slow", 64'(slow),    64'h0);
        check_eq("mid_rst_cont", 64'(cont),    64'h00);
        check_eq("mid_rst_cnt",  64'(cnt),     64'h0);
        check_eq("mid_rst_cfg",  64'(pad_cfg), 64'h0);
        rst = 1'b0;
        idle_inputs();
        chip_pad_cfg = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cvmcu_io_pad_bridge
